// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges the pipeline WB stage and a multi-cycle unit onto one
// register-file write port, with starvation protection for the multi-cycle result.
module wb_port_arbiter #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 3,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mc_valid,
   input  logic [ADDR_W-1:0] mc_addr,
   input  logic [DATA_W-1:0] mc_data,
   output logic              mc_ready,
   output logic              stall,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]  r_starve_cnt;
   logic [CNT_W-1:0]  w_starve_next;
   logic              w_forced;
   logic              w_grant_wb;
   logic              w_grant_mc;
   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [DATA_W-1:0] w_wr_data;

   logic              r_rf_we;
   logic [ADDR_W-1:0] r_rf_waddr;
   logic [DATA_W-1:0] r_rf_wdata;

   always_comb begin
      w_forced      = 1'b0;
      w_grant_wb    = 1'b0;
      w_grant_mc    = 1'b0;
      w_wr_addr     = wb_addr;
      w_wr_data     = wb_data;
      w_wr_en       = 1'b0;
      w_starve_next = '0;

      w_forced   = mc_valid && (r_starve_cnt == CNT_MAX);
      w_grant_wb = wb_valid && !w_forced;
      w_grant_mc = mc_valid && (!wb_valid || w_forced);

      if (w_grant_mc) begin
         w_wr_addr = mc_addr;
         w_wr_data = mc_data;
      end
      // r0 is hard-wired: the handshake completes but the port stays quiet
      w_wr_en = (w_grant_wb || w_grant_mc) && (w_wr_addr != '0);

      if (mc_valid && !w_grant_mc) begin
         w_starve_next = (r_starve_cnt == CNT_MAX) ? r_starve_cnt : r_starve_cnt + CNT_W'(1);
      end
   end

   assign mc_ready = rst_n && w_grant_mc;
   assign stall    = rst_n && wb_valid && w_grant_mc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
         r_rf_we      <= 1'b0;
         r_rf_waddr   <= '0;
         r_rf_wdata   <= '0;
      end else begin
         r_starve_cnt <= w_starve_next;
         r_rf_we      <= w_wr_en;
         if (w_grant_wb || w_grant_mc) begin
            r_rf_waddr <= w_wr_addr;
            r_rf_wdata <= w_wr_data;
         end
      end
   end

   assign rf_we    = r_rf_we;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios followed by randomized
// traffic, checked against a rule-level reference model.
module tb_wb_port_arbiter;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wb_valid = 1'b0;
   logic [AW-1:0] wb_addr = '0;
   logic [DW-1:0] wb_data = '0;
   logic          mc_valid = 1'b0;
   logic [AW-1:0] mc_addr = '0;
   logic [DW-1:0] mc_data = '0;
   logic          mc_ready;
   logic          stall;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data),
      .mc_ready(mc_ready), .stall(stall),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      int   due;
      logic ready;
      logic stl;
   } comb_t;

   typedef struct {
      int            due;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } rf_t;

   comb_t comb_q[$];
   rf_t   rf_q[$];
   comb_t mon_c;
   rf_t   mon_f;

   int total = 0;
   int bad   = 0;

   // Reference model state: how long the multi-cycle result has waited, and the
   // last address/data handed to the register file.
   int            m_wait = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic          m_ready = 1'b0;
   logic          m_stall = 1'b0;

   task automatic step(input logic r, input logic wv, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic mv,
                       input logic [AW-1:0] ma, input logic [DW-1:0] md);
      comb_t c;
      rf_t   f;
      logic  we;
      logic  take_wb;
      logic  take_mc;
      @(posedge clk);
      #1;
      rst_n = r; wb_valid = wv; wb_addr = wa; wb_data = wd;
      mc_valid = mv; mc_addr = ma; mc_data = md;
      we = 1'b0;
      if (!r) begin
         m_ready = 1'b0; m_stall = 1'b0;
         m_wait = 0; m_addr = '0; m_data = '0;
      end else begin
         // multi-cycle unit wins only when the pipeline is idle or it has waited long enough
         take_mc = mv && (!wv || m_wait >= SM);
         take_wb = wv && !take_mc;
         m_ready = take_mc;
         m_stall = wv && take_mc;
         if (take_wb) begin
            we = (wa != 0); m_addr = wa; m_data = wd;
         end else if (take_mc) begin
            we = (ma != 0); m_addr = ma; m_data = md;
         end
         if (mv && !take_mc) m_wait = (m_wait < SM) ? m_wait + 1 : SM;
         else m_wait = 0;
      end
      c.due = cycle; c.ready = m_ready; c.stl = m_stall;
      f.due = cycle + 1; f.we = we; f.addr = m_addr; f.data = m_data;
      comb_q.push_back(c);
      rf_q.push_back(f);
   endtask

   always @(negedge clk) begin
      while (comb_q.size() > 0 && comb_q[0].due <= cycle) begin
         mon_c = comb_q.pop_front();
         total++;
         if (mc_ready !== mon_c.ready) begin
            bad++;
            $display("FAIL mc_ready cyc=%0d got=%0b exp=%0b", cycle, mc_ready, mon_c.ready);
         end
         total++;
         if (stall !== mon_c.stl) begin
            bad++;
            $display("FAIL stall cyc=%0d got=%0b exp=%0b", cycle, stall, mon_c.stl);
         end
      end
      while (rf_q.size() > 0 && rf_q[0].due <= cycle) begin
         mon_f = rf_q.pop_front();
         total++;
         if (rf_we !== mon_f.we || rf_waddr !== mon_f.addr || rf_wdata !== mon_f.data) begin
            bad++;
            $display("FAIL rf_port cyc=%0d got we=%0b a=%0d d=%h exp we=%0b a=%0d d=%h",
                     cycle, rf_we, rf_waddr, rf_wdata, mon_f.we, mon_f.addr, mon_f.data);
         end else begin
            $display("cyc=%0d rf we=%0b a=%0d d=%h", cycle, rf_we, rf_waddr, rf_wdata);
         end
      end
   end

   logic          p_wv;
   logic [AW-1:0] p_wa;
   logic [DW-1:0] p_wd;
   logic          p_mv;
   logic [AW-1:0] p_ma;
   logic [DW-1:0] p_md;
   logic          p_r;

   initial begin
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      // pipeline only, multi-cycle only, idle hold, r0 write
      step(1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
      step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hABCD);
      step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      step(1'b1, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 16'h0);
      // starvation: four refusals, forced on the fifth, pipeline resumes
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 3'd3, 16'h0100 + 16'(k), 1'b1, 3'd6, 16'h6666);
      step(1'b1, 1'b1, 3'd3, 16'h0104, 1'b0, 3'd0, 16'h0);
      // reset with three refusals accumulated; counting restarts from zero
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 3'd1, 16'h0200 + 16'(k), 1'b1, 3'd4, 16'h4444);
      step(1'b0, 1'b1, 3'd1, 16'h0203, 1'b1, 3'd4, 16'h4444);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 3'd1, 16'h0300 + 16'(k), 1'b1, 3'd4, 16'h4444);
      step(1'b1, 1'b1, 3'd1, 16'h0304, 1'b0, 3'd0, 16'h0);
      // same-address collision: mc value lands first, pipeline value overwrites it
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 3'd2, 16'h0050 + 16'(k), 1'b1, 3'd2, 16'h00AA);
      step(1'b1, 1'b1, 3'd2, 16'h0055, 1'b1, 3'd2, 16'h00AA);
      step(1'b1, 1'b1, 3'd2, 16'h0055, 1'b0, 3'd0, 16'h0);
      step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

      // randomized traffic obeying the hold-while-refused protocol on both sources
      p_wv = 1'b0; p_wa = '0; p_wd = '0; p_mv = 1'b0; p_ma = '0; p_md = '0;
      for (int n = 0; n < 400; n++) begin
         if (!p_mv && ($urandom % 3 == 0)) begin
            p_mv = 1'b1; p_ma = AW'($urandom); p_md = DW'($urandom);
         end
         if (!(p_wv && m_stall)) begin
            p_wv = ($urandom % 4 != 0); p_wa = AW'($urandom); p_wd = DW'($urandom);
         end
         p_r = ($urandom % 60 != 0);
         step(p_r, p_wv, p_wa, p_wd, p_mv, p_ma, p_md);
         if (m_ready) p_mv = 1'b0;
      end

      step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (comb_q.size() != 0 || rf_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d/%0d pending exp=0/0", comb_q.size(), rf_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
